spi_rom_streamer: RTL and testbench

SPI_ROM_STREAMER -- requirements
Module: spi_rom_streamer

---
 rtl/spi_rom_streamer.sv | 174 +++++++++++++++++
 tb/tb_spi_rom_streamer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rom_streamer.sv
// spi_rom_streamer: issues a serial-ROM READ (opcode + 24-bit address, MSB
// first) and streams byte_count bytes back through a valid/ready port.
// SPI mode 0, one bit period = two clk cycles (A: sclk low, B: sclk high);
// MISO is sampled on the clk edge that ends phase B.
//
// Ports:
//   clk, reset             sole clock, synchronous active-high reset
//   start                  request pulse, honoured only in IDLE
//   start_addr, byte_count captured with an accepted start
//   busy                   transaction in flight (cycle after start .. IDLE)
//   data_out, data_valid   received byte, held until data_ready handshake
//   data_ready             consumer accept
//   done                   one-cycle pulse when the final byte is consumed
//   spi_cs                 active-high chip select
//   spi_sclk, spi_mosi     SPI clock / command-address out
//   spi_miso               SPI data in
module spi_rom_streamer #(
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter int         LEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      start_addr,
  input  logic [LEN_W-1:0] byte_count,
  output logic             busy,
  output logic [7:0]       data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             done,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, FINISH} state_t;

  state_t           state;
  logic             phase_b;    // 0: phase A (sclk low), 1: phase B (sclk high)
  logic [30:0]      tx_sr;      // header bits still to go out after spi_mosi
  logic [4:0]       bit_cnt;    // header bit index
  logic [7:0]       rx_sr;      // incoming bits; holds a whole byte while parked
  logic [2:0]       rx_cnt;     // bits of current byte already sampled
  logic [LEN_W-1:0] remaining;  // bytes still to be shifted in
  logic             stall;      // complete byte parked in rx_sr, sclk frozen
  logic             pending;    // final byte parked in rx_sr while in FINISH

  logic       handshake;
  logic       can_load;
  logic [7:0] rx_byte;

  assign handshake = data_valid && data_ready;
  // The output register is free if empty or being emptied on this edge.
  assign can_load  = !data_valid || data_ready;
  assign rx_byte   = {rx_sr[6:0], spi_miso};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase_b    <= 1'b0;
      tx_sr      <= '0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      rx_cnt     <= '0;
      remaining  <= '0;
      stall      <= 1'b0;
      pending    <= 1'b0;
      busy       <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      done       <= 1'b0;
      spi_cs     <= 1'b0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
    end else begin
      done <= 1'b0;
      // Consumed byte drops valid unless a later assignment reloads it.
      if (handshake) data_valid <= 1'b0;

      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped, which also
          // keeps chip select low for at least two cycles between frames.
          if (start && !done) begin
            if (byte_count == '0) begin
              done <= 1'b1;
            end else begin
              state     <= CMD;
              busy      <= 1'b1;
              spi_cs    <= 1'b1;
              spi_mosi  <= READ_CMD[7];
              tx_sr     <= {READ_CMD[6:0], start_addr};
              bit_cnt   <= '0;
              phase_b   <= 1'b0;
              rx_cnt    <= '0;
              remaining <= byte_count;
              stall     <= 1'b0;
              pending   <= 1'b0;
            end
          end
        end

        CMD, ADDR: begin
          if (!phase_b) begin
            spi_sclk <= 1'b1;
            phase_b  <= 1'b1;
          end else begin
            spi_sclk <= 1'b0;
            phase_b  <= 1'b0;
            bit_cnt  <= bit_cnt + 5'd1;
            spi_mosi <= tx_sr[30];
            tx_sr    <= {tx_sr[29:0], 1'b0};
            if (bit_cnt == 5'd7) state <= ADDR;
            if (bit_cnt == 5'd31) begin
              state    <= DATA;
              spi_mosi <= 1'b0;
            end
          end
        end

        DATA: begin
          if (stall) begin
            // sclk stays low; the next bit period starts after the release.
            if (handshake) begin
              data_out   <= rx_sr;
              data_valid <= 1'b1;
              stall      <= 1'b0;
            end
          end else if (!phase_b) begin
            spi_sclk <= 1'b1;
            phase_b  <= 1'b1;
          end else begin
            spi_sclk <= 1'b0;
            phase_b  <= 1'b0;
            rx_cnt   <= rx_cnt + 3'd1;
            rx_sr    <= rx_byte;
            if (rx_cnt == 3'd7) begin
              remaining <= remaining - LEN_W'(1);
              if (can_load) begin
                data_out   <= rx_byte;
                data_valid <= 1'b1;
              end
              if (remaining == LEN_W'(1)) begin
                state   <= FINISH;
                spi_cs  <= 1'b0;
                pending <= !can_load;
              end else begin
                stall <= !can_load;
              end
            end
          end
        end

        FINISH: begin
          if (handshake) begin
            if (pending) begin
              data_out   <= rx_sr;
              data_valid <= 1'b1;
              pending    <= 1'b0;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_streamer.sv
// Self-checking bench for spi_rom_streamer. A behavioural serial ROM answers
// the captured READ header; received bytes, cycle positions and SPI mode-0
// shape are compared against expectations computed from the cycle rules.
`timescale 1ns/1ps
module tb_spi_rom_streamer;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [23:0]      start_addr = '0;
  logic [LEN_W-1:0] byte_count = '0;
  logic             data_ready = 1'b0;
  logic             spi_miso = 1'b0;
  logic             busy, data_valid, done, spi_cs, spi_sclk, spi_mosi;
  logic [7:0]       data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_rom_streamer #(.READ_CMD(8'h03), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .byte_count(byte_count), .busy(busy), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .done(done),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents: two fixed bytes at 0x100/0x101, a scramble elsewhere.
  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    if (a == 24'h000100) return 8'hA5;
    if (a == 24'h000101) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {a[3:0], a[7:4]} ^ 8'h5A;
  endfunction

  // Results of the last run_txn.
  logic [7:0]  got[$];
  int          got_cyc[$];
  int          done_cyc, done_n, dv_first, cs_drop, rises, rises_at_120;
  int          mode_err, mosi_err, hold_err, post_done_act;
  int          first_cs_cyc, last_cs_cyc;
  bit          cs_ever, busy_ever, rst_ok;
  logic [31:0] hdr;
  logic [3:0]  c1;

  function automatic int bad_bytes(input logic [23:0] a, input int n);
    int bad = 0;
    if (got.size() != n) bad++;
    for (int k = 0; k < n && k < got.size(); k++)
      if (got[k] !== rom_byte(a + 24'(k))) bad++;
    return bad;
  endfunction

  // Called just after a rising edge. Cycle 0 is the cycle start is high.
  // rmode: 0 ready=1, 1 ready=0 before cycle 120, 2 random ready.
  // extra: keep pulsing start with junk parameters through the done cycle.
  task automatic run_txn(input logic [23:0] a, input int n, input int rmode,
                         input int rst_at, input bit extra, input int tail,
                         input int budget);
    int rel;
    int j;
    logic [7:0] b;
    bit psclk, pmosi, pstall, stop;
    logic [7:0] pdata;
    got.delete(); got_cyc.delete();
    done_cyc = -1; done_n = 0; dv_first = -1; cs_drop = -1; rises = 0;
    rises_at_120 = -1; mode_err = 0; mosi_err = 0; hold_err = 0;
    post_done_act = 0; first_cs_cyc = -1; last_cs_cyc = -1;
    cs_ever = 0; busy_ever = 0; rst_ok = 0; hdr = '0; c1 = '0;
    psclk = 0; pmosi = 0; pstall = 0; pdata = '0; stop = 0;
    start_addr = a; byte_count = n[LEN_W-1:0]; start = 1'b1;
    data_ready = (rmode == 0); spi_miso = 1'b0;
    rel = 0;
    while (!stop) begin
      @(negedge clk);
      if (rel > 0) begin
        if (rel == 1) c1 = {spi_cs, busy, spi_mosi, spi_sclk};
        if (busy) busy_ever = 1;
        if (spi_cs) begin
          cs_ever = 1;
          if (first_cs_cyc < 0) first_cs_cyc = cyc;
          last_cs_cyc = cyc;
        end else if (cs_ever && cs_drop < 0) cs_drop = rel;
        if (done_cyc >= 0 && (busy || spi_cs)) post_done_act = 1;
        if (spi_sclk) begin
          if (psclk || spi_mosi !== pmosi || !spi_cs) mode_err++;
          if (rises < 32) hdr = {hdr[30:0], spi_mosi};
          else if (spi_mosi !== 1'b0) mosi_err++;
          rises++;
        end else if (spi_cs && rises >= 32) begin
          j = rises - 32;
          b = rom_byte(hdr[23:0] + 24'(j / 8));
          spi_miso = b[7 - (j % 8)];
        end
        if (pstall && (data_valid !== 1'b1 || data_out !== pdata)) hold_err++;
        pstall = data_valid && !data_ready;
        pdata = data_out;
        if (data_valid && dv_first < 0) dv_first = rel;
        if (data_valid && data_ready) begin
          got.push_back(data_out);
          got_cyc.push_back(rel);
        end
        if (done) begin
          done_n++;
          if (done_cyc < 0) done_cyc = rel;
        end
        if (rel == 120) rises_at_120 = rises;
        if (rst_at > 0 && rel == rst_at + 1)
          rst_ok = ({spi_cs, spi_sclk, spi_mosi, busy, data_valid, done} == 6'b0)
                   && (data_out == 8'h00);
        psclk = spi_sclk;
        pmosi = spi_mosi;
      end
      @(posedge clk); #1;
      rel++;
      start = extra && (done_cyc < 0);
      start_addr = 24'($urandom);
      byte_count = LEN_W'($urandom);
      reset = (rst_at > 0 && rel == rst_at);
      case (rmode)
        0: data_ready = 1'b1;
        1: data_ready = (rel >= 120);
        default: data_ready = 1'($urandom_range(0, 1));
      endcase
      if (done_cyc >= 0 && rel > done_cyc + tail) stop = 1;
      if (rst_at > 0 && rel == rst_at + 2) stop = 1;
      if (rel >= budget) stop = 1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({spi_cs, spi_sclk, spi_mosi, busy, data_valid, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {spi_cs, spi_sclk, spi_mosi, busy, data_valid, done});
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h expected 00", data_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_txn(24'h000100, 2, 0, 0, 0, 0, 400);
    checks++;
    if (c1 !== 4'b1100) begin
      errors++; $display("FAIL basic_cycle1 cs/busy/mosi/sclk: got %b expected 1100", c1);
    end
    checks++;
    if (hdr !== 32'h03000100) begin
      errors++; $display("FAIL basic_hdr: got %h expected 03000100", hdr);
    end
    checks++;
    if (got.size() !== 2 || got[0] !== 8'hA5 || got[1] !== 8'h3C) begin
      errors++; $display("FAIL basic_bytes: got %0d bytes (%p) expected A5,3C", got.size(), got);
    end
    checks++;
    if (got_cyc.size() !== 2 || got_cyc[0] !== 81 || got_cyc[1] !== 97) begin
      errors++; $display("FAIL basic_valid_cycles: got %p expected 81,97", got_cyc);
    end
    checks++;
    if (done_cyc !== 98 || done_n !== 1) begin
      errors++; $display("FAIL basic_done: cycle %0d count %0d expected 98 x1", done_cyc, done_n);
    end
    checks++;
    if (cs_drop !== 97) begin
      errors++; $display("FAIL basic_cs_drop: got %0d expected 97", cs_drop);
    end
    checks++;
    if (rises !== 48 || mode_err !== 0 || mosi_err !== 0) begin
      errors++; $display("FAIL basic_spi: rises %0d modeerr %0d mosierr %0d expected 48,0,0",
                         rises, mode_err, mosi_err);
    end
  endtask

  task automatic test_zero();
    run_txn(24'($urandom), 0, 0, 0, 1, 2, 50);
    checks++;
    if (done_cyc !== 1 || done_n !== 1) begin
      errors++; $display("FAIL zero_done: cycle %0d count %0d expected 1 x1", done_cyc, done_n);
    end
    checks++;
    if (cs_ever || busy_ever || post_done_act != 0 || got.size() != 0) begin
      errors++; $display("FAIL zero_quiet: cs %0d busy %0d after %0d bytes %0d expected all 0",
                         cs_ever, busy_ever, post_done_act, got.size());
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] a;
    a = 24'($urandom);
    run_txn(a, 4, 1, 0, 0, 0, 600);
    checks++;
    if (dv_first !== 81 || hold_err !== 0) begin
      errors++; $display("FAIL bp_hold: first valid %0d hold errors %0d expected 81,0", dv_first, hold_err);
    end
    checks++;
    if (rises_at_120 !== 48) begin
      errors++; $display("FAIL bp_stall: sclk rises by cycle 120 %0d expected 48", rises_at_120);
    end
    checks++;
    if (bad_bytes(a, 4) != 0) begin
      errors++; $display("FAIL bp_bytes: got %p", got);
    end
    checks++;
    if (got_cyc.size() !== 4 || got_cyc[0] !== 120 || got_cyc[1] !== 121 ||
        got_cyc[2] !== 137 || got_cyc[3] !== 153) begin
      errors++; $display("FAIL bp_cycles: got %p expected 120,121,137,153", got_cyc);
    end
    checks++;
    if (rises !== 64 || done_cyc !== 154 || mode_err !== 0) begin
      errors++; $display("FAIL bp_end: rises %0d done %0d modeerr %0d expected 64,154,0",
                         rises, done_cyc, mode_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] a;
    run_txn(24'($urandom), 8, 0, 40, 0, 0, 100);
    checks++;
    if (!rst_ok || done_n != 0) begin
      errors++; $display("FAIL midreset_outputs: reset values ok %0d done %0d expected 1,0", rst_ok, done_n);
    end
    a = 24'($urandom);
    run_txn(a, 2, 0, 0, 0, 0, 400);
    checks++;
    if (hdr !== {8'h03, a} || dv_first !== 81) begin
      errors++; $display("FAIL midreset_restart: hdr %h first valid %0d expected %h,81", hdr, dv_first, {8'h03, a});
    end
    checks++;
    if (bad_bytes(a, 2) != 0) begin
      errors++; $display("FAIL midreset_bytes: got %p", got);
    end
  endtask

  task automatic test_ignore();
    logic [23:0] a;
    int saved;
    a = 24'($urandom);
    run_txn(a, 3, 0, 0, 1, 2, 400);
    checks++;
    if (bad_bytes(a, 3) != 0 || hdr !== {8'h03, a}) begin
      errors++; $display("FAIL ignore_busy: hdr %h bytes %p", hdr, got);
    end
    checks++;
    if (post_done_act != 0 || done_n != 1) begin
      errors++; $display("FAIL ignore_done_cycle: activity %0d done count %0d expected 0,1", post_done_act, done_n);
    end
    run_txn(24'($urandom), 1, 0, 0, 0, 0, 200);
    saved = last_cs_cyc;
    a = 24'($urandom);
    run_txn(a, 1, 0, 0, 0, 0, 200);
    checks++;
    if (first_cs_cyc - saved - 1 < 2 || bad_bytes(a, 1) != 0) begin
      errors++; $display("FAIL ignore_cs_gap: low cycles %0d expected >=2", first_cs_cyc - saved - 1);
    end
  endtask

  task automatic test_random();
    logic [23:0] a;
    int bad;
    a = 24'($urandom);
    run_txn(a, 256, 2, 0, 0, 0, 20000);
    bad = bad_bytes(a, 256);
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rand_bytes: %0d bad, received %0d of 256", bad, got.size());
    end
    checks++;
    if (rises !== 32 + 8 * 256 || done_n !== 1 || hdr !== {8'h03, a}) begin
      errors++; $display("FAIL rand_count: rises %0d done %0d hdr %h expected %0d,1,%h",
                         rises, done_n, hdr, 32 + 8 * 256, {8'h03, a});
    end
    checks++;
    if (mode_err !== 0 || mosi_err !== 0 || hold_err !== 0) begin
      errors++; $display("FAIL rand_timing: mode %0d mosi %0d hold %0d expected 0,0,0",
                         mode_err, mosi_err, hold_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
